id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode pipeline stage of the RV32I core. It accepts one fetched instruction per handshake from the IF/ID boundary and drives the register-file read addresses. It selects the write-back forwarding path, generates the immediate, and detects load-use hazards, inserting a single bubble when one occurs. Results are registered into the ID/EX pipeline register with a valid/ready handshake toward execute.

## Interface
Parameters:
- None. Opcode and forwarding constants come from `rv32i_types`.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: IF/ID holds an instruction.
- `in_ready` out 1: stage consumes the instruction this cycle.
- `in_pc` in 32: instruction PC.
- `in_inst` in 32: instruction word.
- `flush` in 1: redirect from execute; kill the stage contents.
- `rs1_s`, `rs2_s` out 5 each: register-file read addresses, combinational from `in_inst`.
- `rs1_v`, `rs2_v` in 32 each: register-file read data, same cycle.
- `wb_we` in 1: write-back write enable.
- `wb_rd_s` in 5: write-back destination register.
- `wb_rd_v` in 32: write-back data.
- `fw_sel` out `decode_fw_sel_t`: register-file bypass select; values `none_f`, `rs1_f`, `rs2_f`.
- `out_valid` out 1: ID/EX register holds a valid instruction.
- `out_ready` in 1: execute accepts it.
- `out_pc`, `out_inst`, `out_imm`, `out_rs1_v`, `out_rs2_v` out 32 each: registered values.
- `out_rs1_s`, `out_rs2_s`, `out_rd_s` out 5 each: registered register indices.
- `out_regf_we`, `out_is_load`, `out_illegal` out 1 each: registered control bits.

## Operation
Field extraction:
- `rs1_s` = `in_inst[19:15]`; `rs2_s` = `in_inst[24:20]`; rd = `in_inst[11:7]`.

Operand-use rules:
- `uses_rs1` = 0 for LUI, AUIPC and JAL; 1 for every other opcode.
- `uses_rs2` = 1 only for R-type, store and branch.

Immediate generation (sign-extended from the instruction's bit 31):
- I-type (OP-IMM, LOAD, JALR): immediate from the I-type field.
- S-type: immediate from the S-type field.
- B-type: immediate from the B-type field, bit 0 = 0.
- U-type: `{inst[31:12], 12'b0}`.
- J-type: immediate from the J-type field, bit 0 = 0.
- R-type: immediate = 0.

Control bits:
- `regf_we` = 0 for STORE and BRANCH, 0 when rd = 0, 0 for illegal instructions; 1 otherwise.
- `is_load` = 1 when the opcode is LOAD.
- `illegal` = 1 for an unknown opcode; the instruction still passes through with `regf_we` = 0.

Write-back forwarding:
- `m1` = `wb_we` and `wb_rd_s` ≠ 0 and `wb_rd_s` = `rs1_s` and `uses_rs1`. `m2` is the same test on rs2.
- `fw_sel` = `rs1_f` if `m1`; else `rs2_f` if `m2`; else `none_f`.
- When both `m1` and `m2` hold, the stage substitutes `wb_rd_v` for rs2 internally; the register file bypasses only rs1.

Load-use hazard:
- `hz` = `out_valid` and `out_is_load` and `out_rd_s` ≠ 0 and ((`uses_rs1` and `rs1_s` = `out_rd_s`) or (`uses_rs2` and `rs2_s` = `out_rd_s`)).
- Only evaluated when `in_valid` = 1.

Handshake and next state (priority order):
- `flush`: `in_ready` = 1 and the input is discarded; `out_valid` ← 0.
- `hz` and (`out_ready` or not `out_valid`): `in_ready` = 0; `out_valid` ← 0 (bubble).
- `out_valid` and not `out_ready`: `in_ready` = 0; ID/EX holds unchanged.
- Otherwise: `in_ready` = 1; `out_valid` ← `in_valid`, and all `out_*` load decoded values when `in_valid` = 1.

## Timing
Reset:
- While `rst` = 1: `out_valid` = 0; all `out_*` data and control = 0; `fw_sel` = `none_f`; `rs1_s` = `rs2_s` = 0; `in_ready` = 0.
- Reset asserted mid-operation drops the ID/EX contents immediately, without waiting for a clock edge.

Latency:
- One cycle from `in_valid && in_ready` to `out_valid`.
- Sustained throughput is one instruction per cycle.

Bubbles and stalls:
- A load-use hazard costs exactly one bubble. In the following cycle the load has left ID/EX, so `hz` = 0.
- Outputs are stable while `out_valid && !out_ready`.

Corner cases:
- Back-to-back instructions through a stalled execute must be neither lost nor duplicated.
- `flush` coinciding with a hazard or a stall: `flush` wins.
- x0 never forwards and never hazards.

## Structure
Shared package `rv32i_types` holds:
- the opcode enum `rv32i_opcode_t`;
- `decode_fw_sel_t`;
- the `id_ex_reg_t` struct that bundles the `out_*` fields.

Sub-module:
- `imm_gen` is a natural combinational sub-module: input `inst[31:0]`, output `imm[31:0]`, output `illegal`.
- The ID/EX register, the hazard check and the forwarding logic stay in `id_stage`.

## Test plan
- Reset behaviour: assert `rst` asynchronously mid-cycle → `out_valid` = 0 and `fw_sel` = `none_f` immediately; `in_ready` = 0 until release.
- Straight-line issue: `0x00500093` (ADDI x1,x0,5) → next cycle `out_imm` = 5, `out_rd_s` = 1, `out_regf_we` = 1; `rs1_s` = 0 combinationally.
- Load-use bubble: `0x0000A103` (LW x2,0(x1)) then `0x001101B3` (ADD x3,x2,x1) → one cycle with `in_ready` = 0 and `out_valid` = 0, then ADD issues; total 3 cycles for 2 instructions.
- Write-back forwarding with a double match: `wb_we` = 1, `wb_rd_s` = 1, `wb_rd_v` = `0xDEAD0001` while decoding ADD x3,x1,x1 → `fw_sel` = `rs1_f` and `out_rs2_v` = `0xDEAD0001`.
- Branch immediate: `0xFE000EE3` (BEQ x0,x0,-4) → `out_imm` = `0xFFFFFFFC`, `out_regf_we` = 0.
- Stall and flush: hold `out_ready` = 0 for 3 cycles → outputs stable and `in_ready` = 0; then assert `flush` with `in_valid` = 1 → `in_ready` = 1 and `out_valid` = 0 next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, forwarding select and the ID/EX register layout.
// Operand-use helpers live here so every decoder agrees on them.
package rv32i_types;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_REG      = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [1:0] {
        none_f = 2'd0,
        rs1_f  = 2'd1,
        rs2_f  = 2'd2
    } decode_fw_sel_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic        regf_we;
        logic        is_load;
        logic        illegal;
    } id_ex_reg_t;

    function automatic logic uses_rs1(input rv32i_opcode_t op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input rv32i_opcode_t op);
        return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundles the IF/ID handshake, register-file, write-back and ID/EX signals of the decode stage.
interface id_stage_if;
    import rv32i_types::*;

    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_pc;
    logic [31:0]    in_inst;
    logic           flush;
    logic [4:0]     rs1_s;
    logic [4:0]     rs2_s;
    logic [31:0]    rs1_v;
    logic [31:0]    rs2_v;
    logic           wb_we;
    logic [4:0]     wb_rd_s;
    logic [31:0]    wb_rd_v;
    decode_fw_sel_t fw_sel;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_pc;
    logic [31:0]    out_inst;
    logic [31:0]    out_imm;
    logic [31:0]    out_rs1_v;
    logic [31:0]    out_rs2_v;
    logic [4:0]     out_rs1_s;
    logic [4:0]     out_rs2_s;
    logic [4:0]     out_rd_s;
    logic           out_regf_we;
    logic           out_is_load;
    logic           out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, flush, rs1_v, rs2_v,
               wb_we, wb_rd_s, wb_rd_v, out_ready,
        input  in_ready, rs1_s, rs2_s, fw_sel, out_valid, out_pc, out_inst,
               out_imm, out_rs1_v, out_rs2_v, out_rs1_s, out_rs2_s, out_rd_s,
               out_regf_we, out_is_load, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, rs1_v, rs2_v,
               wb_we, wb_rd_s, wb_rd_v, out_ready,
        output in_ready, rs1_s, rs2_s, fw_sel, out_valid, out_pc, out_inst,
               out_imm, out_rs1_v, out_rs2_v, out_rs1_s, out_rs2_s, out_rd_s,
               out_regf_we, out_is_load, out_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Sign-extended immediate generator; flags opcodes outside RV32I as illegal.
module imm_gen
    import rv32i_types::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output logic        illegal
);

    rv32i_opcode_t op;
    assign op = rv32i_opcode_t'(inst[6:0]);

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OP_REG:
                imm = '0;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: field extraction, write-back forwarding, load-use bubble insertion
// and the ID/EX pipeline register with a valid/ready handshake toward execute.
module id_stage
    import rv32i_types::*;
(
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);

    rv32i_opcode_t op;
    logic [4:0]    rs1, rs2, rd;
    logic          use1, use2, m1, m2, hz;
    logic [31:0]   imm;
    logic          illegal;
    logic          valid_q, valid_d, load_en, ready;
    id_ex_reg_t    q, d;

    assign op   = rv32i_opcode_t'(bus.in_inst[6:0]);
    assign rs1  = bus.in_inst[19:15];
    assign rs2  = bus.in_inst[24:20];
    assign rd   = bus.in_inst[11:7];
    assign use1 = uses_rs1(op);
    assign use2 = uses_rs2(op);

    imm_gen u_imm_gen (
        .inst    (bus.in_inst),
        .imm     (imm),
        .illegal (illegal)
    );

    assign m1 = bus.wb_we && (bus.wb_rd_s != 5'd0) && (bus.wb_rd_s == rs1) && use1;
    assign m2 = bus.wb_we && (bus.wb_rd_s != 5'd0) && (bus.wb_rd_s == rs2) && use2;

    assign hz = bus.in_valid && valid_q && q.is_load && (q.rd_s != 5'd0) &&
                ((use1 && rs1 == q.rd_s) || (use2 && rs2 == q.rd_s));

    // The register file bypasses only one port, so a double match takes rs2 from write-back here.
    always_comb begin
        d         = '0;
        d.pc      = bus.in_pc;
        d.inst    = bus.in_inst;
        d.imm     = imm;
        d.rs1_v   = bus.rs1_v;
        d.rs2_v   = (m1 && m2) ? bus.wb_rd_v : bus.rs2_v;
        d.rs1_s   = rs1;
        d.rs2_s   = rs2;
        d.rd_s    = rd;
        d.is_load = (op == OP_LOAD);
        d.illegal = illegal;
        d.regf_we = !(op == OP_STORE || op == OP_BRANCH) && (rd != 5'd0) && !illegal;
    end

    // Handshake priority: flush, load-use bubble, downstream stall, normal advance.
    always_comb begin
        ready   = 1'b1;
        valid_d = valid_q;
        load_en = 1'b0;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (hz && (bus.out_ready || !valid_q)) begin
            ready   = 1'b0;
            valid_d = 1'b0;
        end else if (valid_q && !bus.out_ready) begin
            ready   = 1'b0;
        end else begin
            valid_d = bus.in_valid;
            load_en = bus.in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_en) begin
                q <= d;
            end
        end
    end

    assign bus.in_ready    = ready && !rst;
    assign bus.rs1_s       = rst ? 5'd0 : rs1;
    assign bus.rs2_s       = rst ? 5'd0 : rs2;
    assign bus.fw_sel      = rst ? none_f : (m1 ? rs1_f : (m2 ? rs2_f : none_f));
    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = q.pc;
    assign bus.out_inst    = q.inst;
    assign bus.out_imm     = q.imm;
    assign bus.out_rs1_v   = q.rs1_v;
    assign bus.out_rs2_v   = q.rs2_v;
    assign bus.out_rs1_s   = q.rs1_s;
    assign bus.out_rs2_s   = q.rs2_s;
    assign bus.out_rd_s    = q.rd_s;
    assign bus.out_regf_we = q.regf_we;
    assign bus.out_is_load = q.is_load;
    assign bus.out_illegal = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, issue, load-use bubble, forwarding,
// immediates, stall/flush and asynchronous mid-run reset, with hand-computed expectations.
module tb_id_stage;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] inst);
        @(negedge clk);
        bus.in_valid = valid;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0;
        bus.in_inst   = 32'h001101B3;
        bus.flush     = 1'b0;
        bus.rs1_v     = 32'h11111111;
        bus.rs2_v     = 32'h22222222;
        bus.wb_we     = 1'b1;
        bus.wb_rd_s   = 5'd2;
        bus.wb_rd_v   = 32'h0;
        bus.out_ready = 1'b1;
        #12;
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("rst_rs1_s", {27'b0, bus.rs1_s}, 32'd0);
        checkOutput("rst_fw_sel", {30'b0, bus.fw_sel}, 32'd0);
        checkOutput("rst_out_pc", bus.out_pc, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_we    = 1'b0;

        // ADDI x1,x0,5
        applyStimulus(1'b1, 32'h100, 32'h00500093);
        #1;
        checkOutput("addi_rs1_s", {27'b0, bus.rs1_s}, 32'd0);
        checkOutput("addi_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        checkOutput("addi_out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("addi_imm", bus.out_imm, 32'd5);
        checkOutput("addi_rd", {27'b0, bus.out_rd_s}, 32'd1);
        checkOutput("addi_we", {31'b0, bus.out_regf_we}, 32'd1);
        checkOutput("addi_pc", bus.out_pc, 32'h100);

        // LW x2,0(x1) then ADD x3,x2,x1: one bubble
        applyStimulus(1'b1, 32'h104, 32'h0000A103);
        #1;
        checkOutput("lw_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        checkOutput("lw_is_load", {31'b0, bus.out_is_load}, 32'd1);
        checkOutput("lw_rd", {27'b0, bus.out_rd_s}, 32'd2);
        checkOutput("lw_imm", bus.out_imm, 32'd0);
        applyStimulus(1'b1, 32'h108, 32'h001101B3);
        #1;
        checkOutput("hz_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        checkOutput("bubble_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("bubble_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        checkOutput("add_out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("add_inst", bus.out_inst, 32'h001101B3);
        checkOutput("add_rd", {27'b0, bus.out_rd_s}, 32'd3);
        checkOutput("add_pc", bus.out_pc, 32'h108);

        // ADD x3,x1,x1 with write-back to x1: both ports match
        applyStimulus(1'b1, 32'h10C, 32'h001081B3);
        bus.wb_we   = 1'b1;
        bus.wb_rd_s = 5'd1;
        bus.wb_rd_v = 32'hDEAD0001;
        #1;
        checkOutput("dbl_fw_sel", {30'b0, bus.fw_sel}, 32'd1);
        tick();
        checkOutput("dbl_rs2_v", bus.out_rs2_v, 32'hDEAD0001);
        checkOutput("dbl_rs1_v", bus.out_rs1_v, 32'h11111111);

        // ADD x3,x2,x5 with write-back to x5: rs2 only, register file bypasses it
        applyStimulus(1'b1, 32'h110, 32'h005101B3);
        bus.wb_rd_s = 5'd5;
        #1;
        checkOutput("rs2_fw_sel", {30'b0, bus.fw_sel}, 32'd2);
        tick();
        checkOutput("rs2_rs2_v", bus.out_rs2_v, 32'h22222222);
        checkOutput("rs2_rs2_s", {27'b0, bus.out_rs2_s}, 32'd5);

        // x0 never forwards
        applyStimulus(1'b1, 32'h114, 32'h00500093);
        bus.wb_rd_s = 5'd0;
        #1;
        checkOutput("x0_fw_sel", {30'b0, bus.fw_sel}, 32'd0);
        tick();

        // JAL x1,8
        applyStimulus(1'b1, 32'h118, 32'h008000EF);
        bus.wb_we = 1'b0;
        tick();
        checkOutput("jal_imm", bus.out_imm, 32'd8);
        checkOutput("jal_we", {31'b0, bus.out_regf_we}, 32'd1);

        // BEQ x0,x0,-4
        applyStimulus(1'b1, 32'h120, 32'hFE000EE3);
        tick();
        checkOutput("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        checkOutput("beq_we", {31'b0, bus.out_regf_we}, 32'd0);

        // Execute stalls for 3 cycles with a new instruction waiting
        applyStimulus(1'b1, 32'h200, 32'h00500093);
        bus.out_ready = 1'b0;
        #1;
        checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc", bus.out_pc, 32'h120);
            checkOutput("stall_inst", bus.out_inst, 32'hFE000EE3);
            checkOutput("stall_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("stall_in_ready2", {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;

        // Unknown opcode 0x7F with rd=x31
        applyStimulus(1'b1, 32'h300, 32'h00000FFF);
        tick();
        checkOutput("ill_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("ill_flag", {31'b0, bus.out_illegal}, 32'd1);
        checkOutput("ill_we", {31'b0, bus.out_regf_we}, 32'd0);
        checkOutput("ill_rd", {27'b0, bus.out_rd_s}, 32'd31);

        // Asynchronous reset between clock edges
        applyStimulus(1'b1, 32'h304, 32'h001081B3);
        bus.wb_we   = 1'b1;
        bus.wb_rd_s = 5'd1;
        tick();
        checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("arst_fw_sel", {30'b0, bus.fw_sel}, 32'd0);
        checkOutput("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("arst_out_pc", bus.out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
